smi_self_link_arbiter: RTL and testbench

- Round-robin, frame-locked arbiter that merges NumInputs SELF-protocol upstream links onto one SELF downstream link.
- Once an input is granted, it keeps the output until the flit marked end-of-frame has transferred, so SMI message frames are never interleaved.
- The output is a single registered stage with full throughput.
- Sits in front of the toggle/elastic link buffers on the shared SMI memory port.

---
 rtl/smi_self_pkg.sv | 19 +
 rtl/smi_rr_priority_select.sv | 29 ++
 rtl/smi_self_link_arbiter.sv | 125 ++++++++++++
 tb/tb_smi_self_link_arbiter.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/smi_self_pkg.sv
// Shared types and helpers for the SMI SELF-link arbiter.
package smi_self_pkg;

  localparam int unsigned DATA_WIDTH_DEFAULT = 16;

  typedef enum logic {
    STATE_IDLE   = 1'b0,
    STATE_LOCKED = 1'b1
  } state_e;

  // Ceiling log2; returns 0 for values of 0 or 1.
  function automatic int unsigned clog2(input int unsigned value);
    int unsigned res;
    res = 0;
    while ((32'd1 << res) < value) res++;
    return res;
  endfunction

endpackage

// File: rtl/smi_rr_priority_select.sv
// Combinational round-robin picker: first requester after lastGrant, wrapping.
module smi_rr_priority_select
  import smi_self_pkg::*;
#(
  parameter int unsigned NumInputs  = 4,
  parameter int unsigned IndexWidth = clog2(NumInputs)
) (
  input  logic [NumInputs-1:0]  request,
  input  logic [IndexWidth-1:0] lastGrant,
  output logic                  anyRequest,
  output logic [IndexWidth-1:0] selectIndex
);

  int unsigned cand;

  always_comb begin
    anyRequest  = 1'b0;
    selectIndex = lastGrant;
    cand        = 0;
    for (int unsigned off = 1; off <= NumInputs; off++) begin
      cand = (32'(lastGrant) + off) % NumInputs;
      if (!anyRequest && request[IndexWidth'(cand)]) begin
        anyRequest  = 1'b1;
        selectIndex = IndexWidth'(cand);
      end
    end
  end

endmodule

// File: rtl/smi_self_link_arbiter.sv
// Frame-locked round-robin merge of NumInputs SELF links onto one registered
// SELF output; a granted input holds the output until its EOF flit transfers.
module smi_self_link_arbiter
  import smi_self_pkg::*;
#(
  parameter int unsigned DataWidth  = DATA_WIDTH_DEFAULT,
  parameter int unsigned NumInputs  = 4,
  parameter int unsigned IndexWidth = clog2(NumInputs)
) (
  input  logic                          clk,
  input  logic                          srst,
  input  logic [NumInputs-1:0]          dataInValid,
  input  logic [NumInputs*DataWidth-1:0] dataIn,
  input  logic [NumInputs-1:0]          dataInEof,
  output logic [NumInputs-1:0]          dataInStop,
  output logic                          dataOutValid,
  output logic [DataWidth-1:0]          dataOut,
  output logic                          dataOutEof,
  input  logic                          dataOutStop,
  output logic [IndexWidth-1:0]         grantIndex,
  output logic                          grantActive
);

  localparam logic [IndexWidth-1:0] LAST_GRANT_RESET = IndexWidth'(NumInputs - 1);

  state_e                state_q, state_d;
  logic [IndexWidth-1:0] grant_idx_q, grant_idx_d;
  logic [IndexWidth-1:0] last_grant_q, last_grant_d;
  logic                  out_valid_q, out_valid_d;
  logic [DataWidth-1:0]  out_data_q, out_data_d;
  logic                  out_eof_q, out_eof_d;

  logic [DataWidth-1:0]  lane_data [NumInputs];
  logic                  any_request;
  logic [IndexWidth-1:0] select_index;
  logic                  sel_valid;
  logic                  sel_eof;
  logic [DataWidth-1:0]  sel_data;
  logic                  can_load;
  logic                  in_xfer;

  for (genvar i = 0; i < NumInputs; i++) begin : g_lane
    assign lane_data[i] = dataIn[i*DataWidth +: DataWidth];
  end

  smi_rr_priority_select #(
    .NumInputs  (NumInputs),
    .IndexWidth (IndexWidth)
  ) u_pick (
    .request     (dataInValid),
    .lastGrant   (last_grant_q),
    .anyRequest  (any_request),
    .selectIndex (select_index)
  );

  // Only the locked input is ever looked at; the others stay stopped.
  always_comb begin
    sel_valid  = dataInValid[grant_idx_q];
    sel_eof    = dataInEof[grant_idx_q];
    sel_data   = lane_data[grant_idx_q];
    can_load   = ~out_valid_q | ~dataOutStop;
    in_xfer    = (state_q == STATE_LOCKED) && sel_valid && can_load;
    dataInStop = '1;
    if (state_q == STATE_LOCKED) dataInStop[grant_idx_q] = ~can_load;
  end

  always_comb begin
    state_d      = state_q;
    grant_idx_d  = grant_idx_q;
    last_grant_d = last_grant_q;
    out_valid_d  = out_valid_q;
    out_data_d   = out_data_q;
    out_eof_d    = out_eof_q;

    case (state_q)
      STATE_IDLE: begin
        if (any_request) begin
          state_d      = STATE_LOCKED;
          grant_idx_d  = select_index;
          last_grant_d = select_index;
        end
      end
      STATE_LOCKED: begin
        if (in_xfer && sel_eof) state_d = STATE_IDLE;
      end
      default: state_d = STATE_IDLE;
    endcase

    // Load wins over unload so back-to-back flits keep valid high.
    if (in_xfer) begin
      out_valid_d = 1'b1;
      out_data_d  = sel_data;
      out_eof_d   = sel_eof;
    end else if (out_valid_q && !dataOutStop) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (srst) begin
      state_q      <= STATE_IDLE;
      grant_idx_q  <= '0;
      last_grant_q <= LAST_GRANT_RESET;
      out_valid_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      grant_idx_q  <= grant_idx_d;
      last_grant_q <= last_grant_d;
      out_valid_q  <= out_valid_d;
    end
  end

  // Payload is qualified by valid, so it carries no reset.
  always_ff @(posedge clk) begin
    out_data_q <= out_data_d;
    out_eof_q  <= out_eof_d;
  end

  assign dataOutValid = out_valid_q;
  assign dataOut      = out_data_q;
  assign dataOutEof   = out_eof_q;
  assign grantIndex   = grant_idx_q;
  assign grantActive  = (state_q == STATE_LOCKED);

endmodule

// File: tb/tb_smi_self_link_arbiter.sv
// Directed bench for smi_self_link_arbiter: per-cycle vector table plus a
// round-robin sequence with four continuously requesting sources.
module tb_smi_self_link_arbiter;

  logic        clk;
  logic        srst;
  logic [3:0]  dataInValid;
  logic [63:0] dataIn;
  logic [3:0]  dataInEof;
  logic [3:0]  dataInStop;
  logic        dataOutValid;
  logic [15:0] dataOut;
  logic        dataOutEof;
  logic        dataOutStop;
  logic [1:0]  grantIndex;
  logic        grantActive;

  smi_self_link_arbiter dut (
    .clk          (clk),
    .srst         (srst),
    .dataInValid  (dataInValid),
    .dataIn       (dataIn),
    .dataInEof    (dataInEof),
    .dataInStop   (dataInStop),
    .dataOutValid (dataOutValid),
    .dataOut      (dataOut),
    .dataOutEof   (dataOutEof),
    .dataOutStop  (dataOutStop),
    .grantIndex   (grantIndex),
    .grantActive  (grantActive)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Lane i carries {i, d8} so the output also shows which input was muxed.
  typedef struct {
    logic        chk;
    logic        rst;
    logic [3:0]  vld;
    logic [3:0]  eof;
    logic [7:0]  d8;
    logic        ostop;
    logic        ov;
    logic [15:0] od;
    logic        oe;
    logic        ga;
    logic [1:0]  gi;
    logic [3:0]  istop;
  } vec_t;

  vec_t tbl [64];
  int   nv;
  int   n_total;
  int   n_pass;

  task automatic add(input logic chk, input logic rst, input logic [3:0] vld,
                     input logic [3:0] eof, input logic [7:0] d8, input logic ostop,
                     input logic ov, input logic [15:0] od, input logic oe,
                     input logic ga, input logic [1:0] gi, input logic [3:0] istop);
    tbl[nv].chk   = chk;
    tbl[nv].rst   = rst;
    tbl[nv].vld   = vld;
    tbl[nv].eof   = eof;
    tbl[nv].d8    = d8;
    tbl[nv].ostop = ostop;
    tbl[nv].ov    = ov;
    tbl[nv].od    = od;
    tbl[nv].oe    = oe;
    tbl[nv].ga    = ga;
    tbl[nv].gi    = gi;
    tbl[nv].istop = istop;
    nv++;
  endtask

  task automatic check(input string name, input int step, input logic [15:0] act,
                       input logic [15:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s step %0d: got %0h, expected %0h", name, step, act, exp);
  endtask

  task automatic apply(input vec_t v);
    srst        = v.rst;
    dataInValid = v.vld;
    dataInEof   = v.eof;
    dataOutStop = v.ostop;
    for (int i = 0; i < 4; i++) dataIn[i*16 +: 16] = {8'(i), v.d8};
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  initial begin
    logic [7:0] cnt [4];
    logic [3:0] stopv;
    int k, ph, f, g, fl;

    nv = 0; n_total = 0; n_pass = 0;
    srst = 1'b1; dataInValid = '0; dataInEof = '0; dataIn = '0; dataOutStop = 1'b0;

    // Reset, then input 2 sends A1 A2 A3
    add(0,1,4'h0,4'h0,8'h00,0, 0,16'h0000,0, 0,2'd0,4'hF);
    add(1,0,4'h0,4'h0,8'h00,0, 0,16'h0000,0, 0,2'd0,4'hF);
    add(1,0,4'h4,4'h0,8'hA1,0, 0,16'h0000,0, 0,2'd0,4'hF);
    add(1,0,4'h4,4'h0,8'hA1,0, 0,16'h0000,0, 1,2'd2,4'hB);
    add(1,0,4'h4,4'h0,8'hA2,0, 1,16'h02A1,0, 1,2'd2,4'hB);
    add(1,0,4'h4,4'h4,8'hA3,0, 1,16'h02A2,0, 1,2'd2,4'hB);
    add(1,0,4'h0,4'h0,8'h00,0, 1,16'h02A3,1, 0,2'd0,4'hF);
    add(1,0,4'h0,4'h0,8'h00,0, 0,16'h0000,0, 0,2'd0,4'hF);
    // Single-flit frame from input 3 with input 0 waiting
    add(1,0,4'h9,4'h8,8'h55,0, 0,16'h0000,0, 0,2'd0,4'hF);
    add(1,0,4'h9,4'h8,8'h55,0, 0,16'h0000,0, 1,2'd3,4'h7);
    add(1,0,4'h1,4'h0,8'h10,0, 1,16'h0355,1, 0,2'd0,4'hF);
    add(1,0,4'h1,4'h1,8'h10,0, 0,16'h0000,0, 1,2'd0,4'hE);
    add(1,0,4'h0,4'h0,8'h00,0, 1,16'h0010,1, 0,2'd0,4'hF);
    // Input 1 frame stalled by 5 cycles of downstream stop
    add(1,0,4'h2,4'h0,8'hB1,0, 0,16'h0000,0, 0,2'd0,4'hF);
    add(1,0,4'h2,4'h0,8'hB1,0, 0,16'h0000,0, 1,2'd1,4'hD);
    for (int s = 0; s < 5; s++)
      add(1,0,4'h2,4'h2,8'hB2,1, 1,16'h01B1,0, 1,2'd1,4'hF);
    add(1,0,4'h2,4'h2,8'hB2,0, 1,16'h01B1,0, 1,2'd1,4'hD);
    add(1,0,4'h0,4'h0,8'h00,0, 1,16'h01B2,1, 0,2'd0,4'hF);
    add(1,0,4'h0,4'h0,8'h00,0, 0,16'h0000,0, 0,2'd0,4'hF);
    // Input 1 drops valid mid-frame (eof set but unqualified), input 2 waits
    add(1,0,4'h2,4'h0,8'hC1,0, 0,16'h0000,0, 0,2'd0,4'hF);
    add(1,0,4'h6,4'h0,8'hC1,0, 0,16'h0000,0, 1,2'd1,4'hD);
    add(1,0,4'h4,4'h6,8'hC2,0, 1,16'h01C1,0, 1,2'd1,4'hD);
    add(1,0,4'h4,4'h6,8'hC2,0, 0,16'h0000,0, 1,2'd1,4'hD);
    add(1,0,4'h4,4'h6,8'hC2,0, 0,16'h0000,0, 1,2'd1,4'hD);
    add(1,0,4'h6,4'h6,8'hC2,0, 0,16'h0000,0, 1,2'd1,4'hD);
    add(1,0,4'h4,4'h4,8'hD1,0, 1,16'h01C2,1, 0,2'd0,4'hF);
    add(1,0,4'h4,4'h4,8'hD1,0, 0,16'h0000,0, 1,2'd2,4'hB);
    add(1,0,4'h0,4'h0,8'h00,0, 1,16'h02D1,1, 0,2'd0,4'hF);
    add(1,0,4'h0,4'h0,8'h00,0, 0,16'h0000,0, 0,2'd0,4'hF);
    // Reset while input 0 is mid-frame; input 0 must regain first priority
    add(1,0,4'h1,4'h0,8'hE0,0, 0,16'h0000,0, 0,2'd0,4'hF);
    add(1,0,4'h1,4'h0,8'hE0,0, 0,16'h0000,0, 1,2'd0,4'hE);
    add(1,0,4'h1,4'h0,8'hE1,0, 1,16'h00E0,0, 1,2'd0,4'hE);
    add(1,1,4'h3,4'h0,8'hE2,0, 1,16'h00E1,0, 1,2'd0,4'hE);
    add(1,0,4'h3,4'h0,8'hE0,0, 0,16'h0000,0, 0,2'd0,4'hF);
    add(1,0,4'h3,4'h0,8'hE0,0, 0,16'h0000,0, 1,2'd0,4'hE);
    add(1,0,4'h3,4'h1,8'hE1,0, 1,16'h00E0,0, 1,2'd0,4'hE);
    add(1,0,4'h2,4'h2,8'hF1,0, 1,16'h00E1,1, 0,2'd0,4'hF);
    add(1,0,4'h2,4'h2,8'hF1,0, 0,16'h0000,0, 1,2'd1,4'hD);
    add(1,0,4'h0,4'h0,8'h00,0, 1,16'h01F1,1, 0,2'd0,4'hF);
    add(1,0,4'h0,4'h0,8'h00,0, 0,16'h0000,0, 0,2'd0,4'hF);

    for (int s = 0; s < nv; s++) begin
      @(negedge clk);
      apply(tbl[s]);
      #1;
      if (tbl[s].chk) begin
        check("out_valid", s, 16'(dataOutValid), 16'(tbl[s].ov));
        check("grant_active", s, 16'(grantActive), 16'(tbl[s].ga));
        check("in_stop", s, 16'(dataInStop), 16'(tbl[s].istop));
        if (tbl[s].ga) check("grant_index", s, 16'(grantIndex), 16'(tbl[s].gi));
        if (tbl[s].ov) begin
          check("out_data", s, dataOut, tbl[s].od);
          check("out_eof", s, 16'(dataOutEof), 16'(tbl[s].oe));
        end
      end
    end

    // Four sources always offering 2-flit frames: grants 0,1,2,3,0 with one gap
    @(negedge clk);
    srst = 1'b1; dataInValid = '0; dataInEof = '0; dataOutStop = 1'b0;
    for (int i = 0; i < 4; i++) cnt[i] = 8'h00;
    for (int c = 0; c < 17; c++) begin
      @(negedge clk);
      srst        = 1'b0;
      dataInValid = 4'hF;
      for (int i = 0; i < 4; i++) begin
        dataIn[i*16 +: 16] = {8'(i), cnt[i]};
        dataInEof[i]       = cnt[i][0];
      end
      #1;
      if (c < 2) begin
        check("rr_out_valid", 100 + c, 16'(dataOutValid), 16'h0);
      end else begin
        k  = c - 2;
        ph = k % 3;
        f  = k / 3;
        g  = f % 4;
        fl = (f / 4) * 2 + ph;
        if (ph == 2) begin
          check("rr_gap", 100 + c, 16'(dataOutValid), 16'h0);
        end else begin
          check("rr_out_valid", 100 + c, 16'(dataOutValid), 16'h1);
          check("rr_out_data", 100 + c, dataOut, {8'(g), 8'(fl)});
          check("rr_out_eof", 100 + c, 16'(dataOutEof), 16'(ph == 1));
          check("rr_grant_active", 100 + c, 16'(grantActive), 16'(ph == 0));
          if (ph == 0) check("rr_grant_index", 100 + c, 16'(grantIndex), 16'(g));
        end
      end
      stopv = dataInStop;
      for (int i = 0; i < 4; i++) if (!stopv[i]) cnt[i] = cnt[i] + 8'h01;
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
